// File: rtl/fp32_pkg.sv
// Shared FP32 multiplier result types and canonical special-value encodings.
package fp32_pkg;

    typedef struct packed {
        logic nan;
        logic inf;
        logic ovf;
        logic unf;
    } fp32_flags_t;

    typedef struct packed {
        fp32_flags_t flags;
        logic [31:0] product;
    } fp32_result_t;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;

endpackage

// File: rtl/fp32_mul_result_buffer_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data reads as zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level_o  = wr_ptr_q - rd_ptr_q;
        rd_en    = pop_i && !empty_o;
        // A pop in the same cycle frees the slot the push is about to fill.
        wr_en    = push_i && (!full_o || rd_en);
        wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(rd_en);
        rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fp32_mul_result_buffer.sv
// Captures each multiplier result on the rising edge of done, queues it, and
// keeps saturating per-exception event counters plus a sticky drop flag.
module fp32_mul_result_buffer
    import fp32_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   done_i,
    input  logic [31:0]            product_i,
    input  logic                   nan_i,
    input  logic                   infinit_i,
    input  logic                   overflow_i,
    input  logic                   underflow_i,
    output logic                   space_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            out_data_o,
    output logic [3:0]             out_flags_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   drop_o,
    input  logic                   clear_i,
    output logic [CNT_W-1:0]       nan_cnt_o,
    output logic [CNT_W-1:0]       inf_cnt_o,
    output logic [CNT_W-1:0]       ovf_cnt_o,
    output logic [CNT_W-1:0]       unf_cnt_o
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_LAST = LW'(DEPTH - 1);

    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       flag_vec;
    fp32_result_t     wr_res;
    fp32_result_t     rd_res;

    sync_fifo #(
        .WIDTH ($bits(fp32_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_res),
        .rdata_o (rd_res),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_comb begin
        flag_vec       = {nan_i, infinit_i, overflow_i, underflow_i};
        wr_res.flags   = flag_vec;
        wr_res.product = product_i;

        push        = done_i && !done_q;
        out_valid_o = !fifo_empty;
        pop         = out_valid_o && out_ready_i;
        out_data_o  = rd_res.product;
        out_flags_o = rd_res.flags;

        space_o = (level_o < LEVEL_FULL) &&
                  !(push && (level_o == LEVEL_LAST) && !pop);

        done_d = done_i;
        drop_d = clear_i ? 1'b0 : (drop_q || (push && fifo_full && !pop));

        // Flag bit i maps to counter i: 3=nan, 2=inf, 1=ovf, 0=unf.
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_i) begin
                cnt_d[i] = '0;
            end else if (push && flag_vec[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            drop_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            done_q <= done_d;
            drop_q <= drop_d;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign drop_o    = drop_q;
    assign nan_cnt_o = cnt_q[3];
    assign inf_cnt_o = cnt_q[2];
    assign ovf_cnt_o = cnt_q[1];
    assign unf_cnt_o = cnt_q[0];

endmodule

// File: doc/fp32_mul_result_buffer.md
Name: fp32_mul_result_buffer

Overview:
- Downstream consumer of multiplier32FP: captures each completed product and its exception flags on the rising edge of done, queues them in a small FIFO, and presents them on a valid/ready stream to the next stage (writeback/accumulator).
- Keeps saturating per-exception event counters for debug and power/verification visibility.
- Provides a space-available signal so the upstream controller withholds start_i when the buffer cannot accept another result.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CNT_W, 16, width of each saturating exception counter.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- done_i  in  1  multiplier done_o; level, held high until start drops.
- product_i  in  32  multiplier product_o.
- nan_i  in  1  multiplier nan_o.
- infinit_i  in  1  multiplier infinit_o.
- overflow_i  in  1  multiplier overflow_o.
- underflow_i  in  1  multiplier underflow_o.
- space_o  out  1  high when at least one free entry exists, counting a capture in flight.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head entry.
- out_data_o  out  32  head product.
- out_flags_o  out  4  head flags {nan, inf, ovf, unf}.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- drop_o  out  1  sticky: a result was lost because the FIFO was full.
- clear_i  in  1  synchronous clear of counters and drop_o; FIFO contents are not affected.
- nan_cnt_o, inf_cnt_o, ovf_cnt_o, unf_cnt_o  out  CNT_W each  saturating event counts.

Behaviour:
- Reset: FIFO empty, level_o=0, out_valid_o=0, out_data_o=0, out_flags_o=0, space_o=1, drop_o=0, all counters 0, done edge register=0.
- Capture: done_q registers done_i. push = done_i & ~done_q, giving one push per done pulse. A long done level does not cause repeated pushes.
- Push writes {flags, product_i} sampled in the same cycle as the edge.
- Latency: the entry is visible on out_valid_o/out_data_o the cycle after the push edge when the FIFO was empty. There is no bypass path.
- Pop: out_valid_o & out_ready_i. The head advances next cycle.
- Output data is driven from the head register/array. It is stable while out_valid_o=1 and out_ready_i=0.
- Full with push and no pop: the entry is discarded, drop_o is set (sticky), and the counters still increment.
- Full with push and pop in the same cycle: the push is accepted and the level is unchanged.
- Empty with pop requested: no effect (out_valid_o=0).
- Pointers: log2(DEPTH) bits plus a wrap bit. full/empty are derived from the pointers, and level_o equals the pointer difference.
- space_o = (level_o < DEPTH) & ~(push & level_o == DEPTH-1 & ~pop). It is registered-equivalent and combinationally valid each cycle.
- Counters: each flag increments its counter on push when set, including dropped pushes. Counters saturate at all-ones.
- clear_i has priority over increment in the same cycle. In that case the counter is 0 afterwards and drop_o is 0.
- rst mid-stream: all state returns to reset values next edge and in-flight entries are lost. If done_i is high during reset, done_q is loaded as 0, so the first cycle after reset with done_i=1 causes a push.

Decomposition:
- Shared package fp32_pkg:
  - typedef fp32_flags_t (struct nan, inf, ovf, unf)
  - typedef fp32_result_t {fp32_flags_t, logic[31:0]}
  - constants for the FP32 canonical qNaN 7FC00000 and infinities.
- One sub-module: sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty/level). The top holds edge detection, counters, drop and space logic.

Test Plan:
- Single result:
  - Stimulus: done_i rises with product_i=40C00000, flags 0, and stays high 3 cycles; out_ready_i=1.
  - Required: exactly one entry; out_valid_o high one cycle after the edge with data 40C00000; level_o returns to 0.
- NaN flag:
  - Stimulus: push with nan_i=1 and product 7FC00000.
  - Required: out_flags_o=4'b1000 and nan_cnt_o=1; other counters stay 0.
- Fill and overflow:
  - Stimulus: out_ready_i=0; issue 9 done pulses with products 1..9.
  - Required: level_o=8; space_o goes low after the 8th push; the 9th is dropped and drop_o=1; draining yields 1..8 in order.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full; done edge in the same cycle as out_ready_i=1.
  - Required: level_o stays 8, drop_o stays 0, and the new value is last in order.
- Counter saturation and clear:
  - Stimulus: CNT_W=4; 17 pushes with overflow_i=1.
  - Required: ovf_cnt_o=15; clear_i coincident with a push gives 0.
- Reset mid-operation:
  - Stimulus: 3 entries queued; rst pulsed for 1 cycle while done_i stays high.
  - Required: all outputs return to reset values; the next cycle a single push occurs (level_o=1).
